// File: rtl/cpu_oci_monitor_mem.sv
// JTAG debug monitor memory: executes take_*_ocimem_* reads/writes on a 256x32 RAM
// and shares that RAM with a single-outstanding CPU slave port (JTAG has priority).
module cpu_oci_monitor_mem #(
  parameter logic [7:0] PROTECT_BASE = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [7:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic [31:0] MonDReg,
  output logic [7:0]  MonAReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA} state_t;

  state_t      state;
  state_t      state_next;
  logic        post_inc;
  logic [31:0] mem [256];

  logic        any_take;
  logic        sel_a;
  logic        sel_na;
  logic        sel_b;
  logic        idle;
  logic        jtag_rd_start;
  logic        jtag_wr_ok;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic        unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // ocimem_b beats ocimem_a action, which beats the no-action read
  assign any_take = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign sel_b    = take_action_ocimem_b;
  assign sel_a    = take_action_ocimem_a & ~take_action_ocimem_b;
  assign sel_na   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

  assign idle          = (state == IDLE);
  assign jtag_rd_start = idle & (sel_na | (sel_a & jdo[34]));
  assign jtag_wr_ok    = idle & sel_b & (MonAReg < PROTECT_BASE);

  assign avs_waitrequest = ~idle | any_take;
  assign cpu_wr          = avs_write & ~avs_waitrequest;
  assign cpu_rd          = avs_read & ~avs_write & ~avs_waitrequest;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (jtag_rd_start) state_next = RD_ADDR;
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = avs_address;
    ram_we    = 1'b0;
    ram_wdata = avs_writedata;
    if (state == RD_ADDR) begin
      ram_addr = MonAReg;
    end else if (jtag_wr_ok) begin
      ram_addr  = MonAReg;
      ram_we    = 1'b1;
      ram_wdata = jdo[34:3];
    end else if (cpu_wr) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // Read data, ready and post-increment all land on the RD_ADDR edge so they are
  // visible two cycles after the strobe; RD_DATA is only a busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      post_inc          <= 1'b0;
      MonDReg           <= '0;
      MonAReg           <= '0;
      monitor_ready     <= 1'b0;
      monitor_error     <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      state             <= state_next;
      avs_readdatavalid <= cpu_rd;
      if (cpu_rd) avs_readdata <= mem[ram_addr];

      if (idle) begin
        if (sel_b) begin
          MonAReg       <= MonAReg + 8'd1;
          monitor_ready <= 1'b1;
          if (MonAReg >= PROTECT_BASE) monitor_error <= 1'b1;
        end else if (sel_a) begin
          MonAReg <= jdo[33:26];
          if (jdo[35]) monitor_error <= 1'b0;
          if (jdo[34]) begin
            monitor_ready <= 1'b0;
            post_inc      <= 1'b0;
          end
        end else if (sel_na) begin
          monitor_ready <= 1'b0;
          post_inc      <= 1'b1;
        end
      end else begin
        if (any_take) monitor_error <= 1'b1;
        if (state == RD_ADDR) begin
          MonDReg       <= mem[ram_addr];
          monitor_ready <= 1'b1;
          if (post_inc) MonAReg <= MonAReg + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_oci_monitor_mem.sv
// Bench for cpu_oci_monitor_mem: directed vector table, hand-written corner
// sequences, then random JTAG/CPU traffic against a transaction-level model.
module tb_cpu_oci_monitor_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready;
  logic        monitor_error;

  always #5 clk = ~clk;

  cpu_oci_monitor_mem dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_readdatavalid       (avs_readdatavalid),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  typedef enum logic [2:0] {OP_LOAD, OP_NA, OP_WR, OP_CPUWR, OP_CPURD} op_e;

  typedef struct {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        rd;
    logic        clr;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [7:0]  exp_areg;
    logic        exp_err;
    logic        exp_ready;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [31:0] m_mem [256];
  logic [7:0]  m_areg;
  logic [31:0] m_dreg;
  logic        m_err;
  logic        m_ready;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: waitrequest never dropped, expected acceptance", name);
  endtask

  function automatic vec_t mk(op_e op, logic [7:0] addr, logic [31:0] data, logic rd, logic clr,
                              logic chk, logic [31:0] ed, logic [7:0] ea, logic ee, logic er);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.rd = rd; v.clr = clr;
    v.chk_data = chk; v.exp_data = ed; v.exp_areg = ea; v.exp_err = ee; v.exp_ready = er;
    return v;
  endfunction

  // Behavioural model: applies each operation's architectural effect and fills in expectations
  function automatic vec_t modelPredict(vec_t v);
    vec_t r = v;
    r.chk_data = 1'b0;
    case (v.op)
      OP_LOAD: begin
        m_areg = v.addr;
        if (v.clr) m_err = 1'b0;
        if (v.rd) begin
          m_dreg = m_mem[m_areg];
          m_ready = 1'b1;
          r.chk_data = 1'b1;
        end
      end
      OP_NA: begin
        m_dreg = m_mem[m_areg];
        m_areg = 8'(m_areg + 1);
        m_ready = 1'b1;
        r.chk_data = 1'b1;
      end
      OP_WR: begin
        if (m_areg < 8'hF0) m_mem[m_areg] = v.data;
        else m_err = 1'b1;
        m_areg = 8'(m_areg + 1);
        m_ready = 1'b1;
      end
      OP_CPUWR: m_mem[v.addr] = v.data;
      default: begin
        r.chk_data = 1'b1;
        m_dreg = m_dreg;
      end
    endcase
    r.exp_data = (v.op == OP_CPURD) ? m_mem[v.addr] : m_dreg;
    r.exp_areg = m_areg;
    r.exp_err = m_err;
    r.exp_ready = m_ready;
    return r;
  endfunction

  task automatic jtagStrobe(input int kind, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b = (kind == 2);
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic cpuWrite(input logic [7:0] addr, input logic [31:0] data);
    int waits = 0;
    @(negedge clk);
    avs_write = 1'b1;
    avs_address = addr;
    avs_writedata = data;
    #1;
    while (avs_waitrequest && waits < 20) begin
      waits++;
      @(negedge clk);
      #1;
    end
    if (waits >= 20) timeoutFail("cpu_write_accept");
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic cpuRead(input logic [7:0] addr, output logic [31:0] got);
    int waits = 0;
    @(negedge clk);
    avs_read = 1'b1;
    avs_address = addr;
    #1;
    while (avs_waitrequest && waits < 20) begin
      waits++;
      @(negedge clk);
      #1;
    end
    if (waits >= 20) timeoutFail("cpu_read_accept");
    @(negedge clk);
    avs_read = 1'b0;
    checkOutput("cpu_rdvalid_high", {31'd0, avs_readdatavalid}, 32'd1);
    got = avs_readdata;
    @(negedge clk);
    checkOutput("cpu_rdvalid_pulse", {31'd0, avs_readdatavalid}, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v, output logic [31:0] got);
    logic [37:0] j = '0;
    got = '0;
    case (v.op)
      OP_LOAD: begin
        j[35] = v.clr;
        j[34] = v.rd;
        j[33:26] = v.addr;
        jtagStrobe(0, j);
        if (v.rd) begin
          checkOutput("ready_low_after_read", {31'd0, monitor_ready}, 32'd0);
          @(negedge clk);
        end
        got = MonDReg;
      end
      OP_NA: begin
        jtagStrobe(1, j);
        checkOutput("ready_low_after_read", {31'd0, monitor_ready}, 32'd0);
        @(negedge clk);
        got = MonDReg;
      end
      OP_WR: begin
        j[34:3] = v.data;
        jtagStrobe(2, j);
        got = MonDReg;
      end
      OP_CPUWR: cpuWrite(v.addr, v.data);
      default: cpuRead(v.addr, got);
    endcase
  endtask

  task automatic checkVector(input string tag, input vec_t v, input logic [31:0] got);
    if (v.chk_data) checkOutput({tag, "_data"}, got, v.exp_data);
    checkOutput({tag, "_areg"}, {24'd0, MonAReg}, {24'd0, v.exp_areg});
    checkOutput({tag, "_err"}, {31'd0, monitor_error}, {31'd0, v.exp_err});
    checkOutput({tag, "_ready"}, {31'd0, monitor_ready}, {31'd0, v.exp_ready});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs [16];
    vec_t        v;
    logic [31:0] got;
    logic [37:0] j;
    int          waits;

    vecs[0]  = mk(OP_LOAD,  8'h10, 32'h0,        0, 0, 0, 32'h0,        8'h10, 0, 0);
    vecs[1]  = mk(OP_WR,    8'h00, 32'hDEADBEEF, 0, 0, 0, 32'h0,        8'h11, 0, 1);
    vecs[2]  = mk(OP_LOAD,  8'h10, 32'h0,        1, 0, 1, 32'hDEADBEEF, 8'h10, 0, 1);
    vecs[3]  = mk(OP_LOAD,  8'hFF, 32'h0,        0, 0, 0, 32'h0,        8'hFF, 0, 1);
    vecs[4]  = mk(OP_NA,    8'h00, 32'h0,        0, 0, 1, 32'hA50000FF, 8'h00, 0, 1);
    vecs[5]  = mk(OP_NA,    8'h00, 32'h0,        0, 0, 1, 32'hA5000000, 8'h01, 0, 1);
    vecs[6]  = mk(OP_LOAD,  8'hF0, 32'h0,        0, 0, 0, 32'h0,        8'hF0, 0, 1);
    vecs[7]  = mk(OP_WR,    8'h00, 32'h1,        0, 0, 0, 32'h0,        8'hF1, 1, 1);
    vecs[8]  = mk(OP_CPURD, 8'hF0, 32'h0,        0, 0, 1, 32'hA50000F0, 8'hF1, 1, 1);
    vecs[9]  = mk(OP_LOAD,  8'h00, 32'h0,        0, 1, 0, 32'h0,        8'h00, 0, 1);
    vecs[10] = mk(OP_CPUWR, 8'hF8, 32'h12345678, 0, 0, 0, 32'h0,        8'h00, 0, 1);
    vecs[11] = mk(OP_CPURD, 8'hF8, 32'h0,        0, 0, 1, 32'h12345678, 8'h00, 0, 1);
    vecs[12] = mk(OP_LOAD,  8'hF8, 32'h0,        1, 0, 1, 32'h12345678, 8'hF8, 0, 1);
    vecs[13] = mk(OP_WR,    8'h00, 32'h5,        0, 0, 0, 32'h0,        8'hF9, 1, 1);
    vecs[14] = mk(OP_LOAD,  8'hFF, 32'h0,        0, 1, 0, 32'h0,        8'hFF, 0, 1);
    vecs[15] = mk(OP_WR,    8'h00, 32'h7,        0, 0, 0, 32'h0,        8'h00, 1, 1);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_dreg", MonDReg, 32'h0);
    checkOutput("reset_areg", {24'd0, MonAReg}, 32'h0);
    checkOutput("reset_ready", {31'd0, monitor_ready}, 32'h0);
    checkOutput("reset_err", {31'd0, monitor_error}, 32'h0);
    checkOutput("reset_rdvalid", {31'd0, avs_readdatavalid}, 32'h0);
    checkOutput("reset_rdata", avs_readdata, 32'h0);
    checkOutput("reset_waitreq", {31'd0, avs_waitrequest}, 32'h0);

    for (int i = 0; i < 256; i++) cpuWrite(8'(i), 32'hA5000000 | 32'(i));

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], got);
      checkVector($sformatf("vec%0d", i), vecs[i], got);
    end

    // CPU write colliding with a JTAG load+read (with error clear) in the same cycle
    j = '0;
    j[35] = 1'b1;
    j[34] = 1'b1;
    j[33:26] = 8'h05;
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = 1'b1;
    avs_write = 1'b1;
    avs_address = 8'h20;
    avs_writedata = 32'hCAFEF00D;
    waits = 0;
    #1;
    while (avs_waitrequest && waits < 20) begin
      waits++;
      @(negedge clk);
      take_action_ocimem_a = 1'b0;
      jdo = '0;
      #1;
    end
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    @(negedge clk);
    avs_write = 1'b0;
    checkOutput("collide_wait_cycles", 32'(waits), 32'd3);
    checkOutput("collide_dreg", MonDReg, 32'hA5000005);
    checkOutput("collide_err_cleared", {31'd0, monitor_error}, 32'd0);
    v = mk(OP_LOAD, 8'h20, 32'h0, 1, 0, 1, 32'hCAFEF00D, 8'h20, 0, 1);
    applyStimulus(v, got);
    checkVector("collide_readback", v, got);

    // Second strobe while the first read is still busy
    v = mk(OP_LOAD, 8'h40, 32'h0, 0, 0, 0, 32'h0, 8'h40, 0, 1);
    applyStimulus(v, got);
    checkVector("dbl_load", v, got);
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    checkOutput("dbl_ready_low", {31'd0, monitor_ready}, 32'd0);
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    checkOutput("dbl_dreg", MonDReg, 32'hA5000040);
    checkOutput("dbl_err", {31'd0, monitor_error}, 32'd1);
    @(negedge clk);
    checkOutput("dbl_single_inc", {24'd0, MonAReg}, 32'h41);

    // Reset arriving one cycle into a no-action read
    v = mk(OP_LOAD, 8'h33, 32'h0, 0, 1, 0, 32'h0, 8'h33, 0, 1);
    applyStimulus(v, got);
    checkVector("rst_load", v, got);
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_ready", {31'd0, monitor_ready}, 32'd0);
    checkOutput("midrst_areg", {24'd0, MonAReg}, 32'h0);
    @(negedge clk);
    checkOutput("midrst_no_late_ready", {31'd0, monitor_ready}, 32'd0);
    checkOutput("midrst_no_late_inc", {24'd0, MonAReg}, 32'h0);

    // Random traffic against the model, starting from a fresh reset and random RAM
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_areg = '0;
    m_dreg = '0;
    m_err = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = $urandom;
      cpuWrite(8'(i), m_mem[i]);
    end
    for (int i = 0; i < 250; i++) begin
      int r = $urandom_range(0, 9);
      v = mk(OP_CPURD, 8'($urandom), $urandom, 0, 0, 0, 32'h0, 8'h0, 0, 0);
      if (r <= 2) begin
        v.op = OP_LOAD;
        if ($urandom_range(0, 1) == 1) v.addr = 8'($urandom_range(232, 255));
        v.rd = 1'($urandom_range(0, 1));
        v.clr = ($urandom_range(0, 3) == 0);
      end else if (r <= 4) begin
        v.op = OP_NA;
      end else if (r <= 6) begin
        v.op = OP_WR;
      end else if (r == 7) begin
        v.op = OP_CPUWR;
      end
      v = modelPredict(v);
      applyStimulus(v, got);
      checkVector($sformatf("rnd%0d", i), v, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
